// File: rtl/md_ref_pkg.sv
// Shared types and constants for the reference-position read path.
//   state_t    : sequencer states (IDLE, ISSUE, DRAIN, FINISH)
//   RD_LATENCY : fixed read latency of the refx/refy/refz RAMs, in cycles
package md_ref_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/ref_fwft_fifo.sv
// Small synchronous first-word-fall-through FIFO.
//   clock   in   rising-edge clock
//   rst     in   synchronous active-high reset (clears pointers, count, storage)
//   wr_en   in   write wr_data (ignored when full)
//   wr_data in   WIDTH
//   rd_en   in   pop the head entry (ignored when empty)
//   rd_data out  WIDTH, current head entry
//   empty   out  no entries stored
//   count   out  number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module ref_fwft_fifo #(
    parameter int unsigned WIDTH = 105,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ref_position_reader.sv
// Read sequencer for the refx/refy/refz position RAMs.
// On start it sweeps addresses 0..N-1 (N = min(num_particles, DEPTH)), absorbs the
// RAM read latency and delivers {x, y, z, index} on a valid/ready stream.
//   clock, rst            clock and synchronous active-high reset
//   start, num_particles  sweep request; sampled only while idle
//   busy, done            sweep in progress / one-cycle completion pulse
//   mem_address, mem_rden, mem_wren   shared RAM control (never writes)
//   refx_q, refy_q, refz_q            RAM read data
//   out_valid, out_ready, out_refx/y/z, out_index   output stream
// Reads are only issued while FIFO occupancy plus in-flight reads leaves room,
// so no read can ever be dropped.
module ref_position_reader
    import md_ref_pkg::*;
#(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_particles,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] refx_q,
    input  logic [DATA_WIDTH-1:0] refy_q,
    input  logic [DATA_WIDTH-1:0] refz_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_refx,
    output logic [DATA_WIDTH-1:0] out_refy,
    output logic [DATA_WIDTH-1:0] out_refz,
    output logic [ADDR_WIDTH-1:0] out_index
);

    localparam int unsigned FW = 3*DATA_WIDTH + ADDR_WIDTH;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned NW = ADDR_WIDTH + 1;

    state_t                state;
    logic [NW-1:0]         n_lat;
    logic [NW-1:0]         n_clamped;
    logic [NW-1:0]         acc_cnt;
    logic [ADDR_WIDTH-1:0] issue_addr;

    logic [RD_LATENCY-1:0] pipe_v;
    logic [ADDR_WIDTH-1:0] pipe_idx [RD_LATENCY];

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [FW-1:0]         fifo_rdata;
    logic [CW:0]           inflight;
    logic [CW:0]           occupancy;
    logic                  accept;
    logic                  last_issue;
    logic                  last_accept;

    assign n_clamped   = (num_particles > NW'(DEPTH)) ? NW'(DEPTH) : num_particles;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + (CW+1)'(pipe_v[i]);
        end
    end

    assign occupancy   = (CW+1)'(fifo_count) + inflight;
    assign mem_rden    = (state == ISSUE) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign mem_address = issue_addr;
    assign mem_wren    = 1'b0;

    assign out_valid   = !fifo_empty;
    assign accept      = out_valid && out_ready;
    assign last_issue  = ({1'b0, issue_addr} == n_lat - NW'(1));
    assign last_accept = accept && (acc_cnt == n_lat - NW'(1));

    assign {out_refx, out_refy, out_refz, out_index} = fifo_rdata;

    // Latency tracker: stage RD_LATENCY-1 lines up with the RAM q of that read.
    always_ff @(posedge clock) begin
        if (rst) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_v[0]   <= mem_rden;
            pipe_idx[0] <= issue_addr;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            n_lat      <= '0;
            acc_cnt    <= '0;
            issue_addr <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                acc_cnt <= acc_cnt + NW'(1);
            end
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start && !busy) begin
                        n_lat      <= n_clamped;
                        acc_cnt    <= '0;
                        issue_addr <= '0;
                        busy       <= 1'b1;
                        state      <= (n_clamped == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_rden) begin
                        if (last_issue) begin
                            state <= DRAIN;
                        end else begin
                            issue_addr <= issue_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    // An empty sweep has no final acceptance to hang done on, so it
                    // pulses one cycle later, with busy stretched to cover it.
                    state <= IDLE;
                    busy  <= (n_lat == '0);
                    done  <= (n_lat == '0);
                end
                default: state <= IDLE;
            endcase
        end
    end

    ref_fwft_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (pipe_v[RD_LATENCY-1]),
        .wr_data ({refx_q, refy_q, refz_q, pipe_idx[RD_LATENCY-1]}),
        .rd_en   (out_ready),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_ref_position_reader.sv
// Directed bench for ref_position_reader. RAMs are modelled as 2-cycle registered
// ROMs whose word is {axis, index}; each table row runs one sweep.
module tb_ref_position_reader;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int DEP = 512;

    logic          clock = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   num_particles;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] refx_q;
    logic [DW-1:0] refy_q;
    logic [DW-1:0] refz_q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_refx;
    logic [DW-1:0] out_refy;
    logic [DW-1:0] out_refz;
    logic [AW-1:0] out_index;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ref_position_reader #(
        .DEPTH      (DEP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .start         (start),
        .num_particles (num_particles),
        .busy          (busy),
        .done          (done),
        .mem_address   (mem_address),
        .mem_rden      (mem_rden),
        .mem_wren      (mem_wren),
        .refx_q        (refx_q),
        .refy_q        (refy_q),
        .refz_q        (refz_q),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_refx      (out_refx),
        .out_refy      (out_refy),
        .out_refz      (out_refz),
        .out_index     (out_index)
    );

    function automatic logic [DW-1:0] word(input int axis, input int idx);
        return (DW'(axis) << 28) | DW'(idx);
    endfunction

    // Two-stage registered ROM: address in cycle t, q valid in cycle t+2.
    logic [AW-1:0] rom_a1;
    always @(posedge clock) begin
        rom_a1 <= mem_address;
        refx_q <= word(1, int'(rom_a1));
        refy_q <= word(2, int'(rom_a1));
        refz_q <= word(3, int'(rom_a1));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int n;          // num_particles
        int rmode;      // 0: ready always 1, 1: ready toggles 1-0-1-0
        int repulse;    // cycle of an extra start pulse, -1 none
        int rst_at;     // cycle rst is asserted, -1 none
        int exp_words;  // -1: not checked
        int exp_first;  // cycle of first accepted word, -1: not checked
        int exp_done;   // cycle of done pulse, -1: not checked
        int exp_dones;  // number of done pulses
        int exp_last;   // last accepted index, -1: not checked
    } vec_t;

    task automatic run_sweep(input int row, input vec_t v);
        int  clamp     = (v.n > DEP) ? DEP : v.n;
        int  next_idx  = 0;
        int  words     = 0;
        int  first     = -1;
        int  done_at   = -1;
        int  dones     = 0;
        int  last      = -1;
        int  order_err = 0;
        int  data_err  = 0;
        int  busy_err  = 0;
        int  issued    = 0;
        int  accepted  = 0;
        int  max_out   = 0;
        int  max_addr  = 0;
        int  outstanding;
        bit  exp_busy;
        bit  finished  = 0;
        string tag;

        tag = $sformatf("row%0d_n%0d", row, v.n);
        for (int rel = 0; rel < 3000; rel++) begin
            @(negedge clock);
            start         = (rel == 0) || (rel == v.repulse);
            num_particles = (AW+1)'(v.n);
            out_ready     = (v.rmode == 0) ? 1'b1 : ((rel % 2) == 0);
            rst           = (rel == v.rst_at);
            #1;
            if (v.rst_at >= 0 && rel == v.rst_at + 1) begin
                chk({tag, "_rst_idle"}, int'({out_valid, busy, mem_rden, done}), 0);
                finished = 1;
                break;
            end
            if (mem_rden) begin
                issued++;
                if (int'(mem_address) > max_addr) max_addr = int'(mem_address);
            end
            outstanding = issued - accepted;
            if (outstanding > max_out) max_out = outstanding;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = rel;
            end
            exp_busy = (rel >= 1) && (done_at < 0 || done_at == rel);
            if (busy != exp_busy) busy_err++;
            if (out_valid && out_ready) begin
                words++;
                if (first < 0) first = rel;
                if (int'(out_index) != next_idx) order_err++;
                if (out_refx != word(1, next_idx) || out_refy != word(2, next_idx) ||
                    out_refz != word(3, next_idx)) data_err++;
                last = int'(out_index);
                next_idx++;
                accepted++;
            end
            if (done_at >= 0 && rel >= done_at + 3) begin
                finished = 1;
                break;
            end
        end
        start     = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b0;

        chk({tag, "_terminated"}, int'(finished), 1);
        if (v.exp_words >= 0) chk({tag, "_words"}, words, v.exp_words);
        if (v.exp_first >= 0) chk({tag, "_first_cycle"}, first, v.exp_first);
        if (v.exp_done >= 0)  chk({tag, "_done_cycle"}, done_at, v.exp_done);
        if (v.exp_last >= 0)  chk({tag, "_last_index"}, last, v.exp_last);
        chk({tag, "_done_pulses"}, dones, v.exp_dones);
        chk({tag, "_order_err"}, order_err, 0);
        chk({tag, "_data_err"}, data_err, 0);
        chk({tag, "_busy_err"}, busy_err, 0);
        chk({tag, "_outstanding_le4"}, int'(max_out <= 4), 1);
        chk({tag, "_wren"}, int'(mem_wren), 0);
        if (v.rst_at < 0) begin
            chk({tag, "_reads_issued"}, issued, clamp);
            if (clamp > 0) chk({tag, "_max_addr"}, max_addr, clamp - 1);
        end
    endtask

    vec_t vecs[9];

    initial begin
        //           n  rm rep rst words first done dones last
        vecs[0] = '{  8, 0, -1, -1,   8,  4,  12, 1,   7};
        vecs[1] = '{  0, 0, -1, -1,   0, -1,   2, 1,  -1};
        vecs[2] = '{ 16, 1, -1, -1,  16, -1,  -1, 1,  15};
        vecs[3] = '{600, 0, -1, -1, 512,  4, 516, 1, 511};
        vecs[4] = '{  8, 0,  3, -1,   8,  4,  12, 1,   7};
        vecs[5] = '{ 32, 0, -1,  6,  -1,  4,  -1, 0,  -1};
        vecs[6] = '{  4, 0, -1, -1,   4,  4,   8, 1,   3};
        vecs[7] = '{  1, 0, -1, -1,   1,  4,   5, 1,   0};
        vecs[8] = '{512, 0, -1, -1, 512,  4, 516, 1, 511};

        rst           = 1'b1;
        start         = 1'b0;
        out_ready     = 1'b0;
        num_particles = '0;
        repeat (3) @(negedge clock);
        #1;
        chk("reset_ctrl", int'({busy, done, mem_rden, out_valid, mem_wren}), 0);
        chk("reset_addr", int'(mem_address), 0);
        chk("reset_index", int'(out_index), 0);
        @(negedge clock);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        for (int r = 0; r < 9; r++) begin
            run_sweep(r, vecs[r]);
            repeat (2) @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
